rv_ctl: RTL



---
 rtl/rv_ctl_pkg.sv | 69 ++++++
 rtl/rv_ctl_if.sv | 33 +++
 rtl/rv_ctl_dec.sv | 72 +++++++
 rtl/rv_ctl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/rv_ctl_pkg.sv
// Shared constants, state and instruction-class types for the multicycle RISC-V controller.
// RV_CTL_ILLEGAL_EN adds the HALT state used when illegal instructions stop the core.
package rv_ctl_pkg;

  localparam logic       PC_PLUS4  = 1'b0;
  localparam logic       PC_ALU    = 1'b1;

  localparam logic [1:0] WB_MDR    = 2'd0;
  localparam logic [1:0] WB_ALUOUT = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  localparam logic [1:0] IMM_J     = 2'd0;
  localparam logic [1:0] IMM_B     = 2'd1;
  localparam logic [1:0] IMM_S     = 2'd2;
  localparam logic [1:0] IMM_L     = 2'd3;

  localparam logic       ALUA_REG  = 1'b0;
  localparam logic       ALUA_PCC  = 1'b1;
  localparam logic       ALUB_REG  = 1'b0;
  localparam logic       ALUB_IMM  = 1'b1;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_W      = 3'b010;

`ifdef RV_CTL_ILLEGAL_EN
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
`else
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
`endif

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_BR, CLS_JAL, CLS_JALR, CLS_ILL
  } cls_t;

  // alt is funct7[5]; it only changes the op for funct3 000 (SUB) and 101 (SRA)
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_ctl_if.sv
// Control bundle between the controller (master) and the datapath (slave).
interface rv_ctl_if #(parameter int DPWIDTH = 32) ();

  logic [DPWIDTH-1:0] instr;
  logic               zero;
  logic               pcsourse;
  logic               pcwrite;
  logic               pccen;
  logic               irwrite;
  logic [1:0]         wbsel;
  logic               regwen;
  logic [1:0]         immsel;
  logic               asel;
  logic               bsel;
  logic [3:0]         alusel;
  logic               mdrwrite;
  logic               dmem_ren;
  logic               dmem_wen;
  logic               illegal;

  modport master (
    input  instr, zero,
    output pcsourse, pcwrite, pccen, irwrite, wbsel, regwen, immsel,
           asel, bsel, alusel, mdrwrite, dmem_ren, dmem_wen, illegal
  );

  modport slave (
    output instr, zero,
    input  pcsourse, pcwrite, pccen, irwrite, wbsel, regwen, immsel,
           asel, bsel, alusel, mdrwrite, dmem_ren, dmem_wen, illegal
  );

endinterface

// File: rtl/rv_ctl_dec.sv
// Combinational instruction decoder: class, EXEC-step ALU op and immediate format, legality.
module rv_ctl_dec
  import rv_ctl_pkg::*;
#(
  parameter int DPWIDTH = 32
) (
  input  logic [DPWIDTH-1:0] instr,
  output cls_t               cls,
  output logic [3:0]         alu_op,
  output logic [1:0]         imm_op,
  output logic               legal,
  output logic               br_ne
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic       f7b5;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign f3          = instr[14:12];
  assign f7b5        = instr[30];
  assign br_ne       = f3[0];
  assign unused_bits = ^{instr[DPWIDTH-1:31], instr[29:15], instr[11:7]};

  always_comb begin
    cls    = CLS_ILL;
    alu_op = ALU_ADD;
    imm_op = IMM_L;
    legal  = 1'b0;
    case (opcode)
      OP_REG: begin
        cls    = CLS_R;
        alu_op = alu_from_f3(f3, f7b5);
        legal  = 1'b1;
      end
      OP_IMM: begin
        cls    = CLS_I;
        alu_op = alu_from_f3(f3, 1'b0);
        // SRAI is rejected: the datapath shifts by the whole B operand, so the
        // funct7 bits inside the immediate would corrupt the shift amount
        legal  = !((f3 == 3'b101) && f7b5);
      end
      OP_LOAD: begin
        cls   = CLS_LW;
        legal = (f3 == F3_W);
      end
      OP_STORE: begin
        cls    = CLS_SW;
        imm_op = IMM_S;
        legal  = (f3 == F3_W);
      end
      OP_BRANCH: begin
        cls    = CLS_BR;
        alu_op = ALU_SUB;
        imm_op = IMM_B;
        legal  = (f3[2:1] == 2'b00);
      end
      OP_JAL: begin
        cls    = CLS_JAL;
        imm_op = IMM_J;
        legal  = 1'b1;
      end
      OP_JALR: begin
        cls   = CLS_JALR;
        legal = (f3 == 3'b000);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv_ctl.sv
// Multicycle control FSM (FETCH/DECODE/EXEC/MEM/WB) driving every datapath enable and select.
// Define RV_CTL_ILLEGAL_EN to halt on illegal instructions; otherwise they retire as NOPs.
module rv_ctl
  import rv_ctl_pkg::*;
#(
  parameter int DPWIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  rv_ctl_if.master  bus
);

  state_t     state, state_nxt;
  cls_t       cls;
  logic [3:0] alu_op;
  logic [1:0] imm_op;
  logic       legal;
  logic       br_ne;
  logic       taken;

  rv_ctl_dec #(.DPWIDTH(DPWIDTH)) u_dec (
    .instr  (bus.instr),
    .cls    (cls),
    .alu_op (alu_op),
    .imm_op (imm_op),
    .legal  (legal),
    .br_ne  (br_ne)
  );

  assign taken = br_ne ? ~bus.zero : bus.zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.pcsourse = PC_PLUS4;
    bus.pcwrite  = 1'b0;
    bus.pccen    = 1'b0;
    bus.irwrite  = 1'b0;
    bus.wbsel    = WB_MDR;
    bus.regwen   = 1'b0;
    bus.immsel   = IMM_J;
    bus.asel     = ALUA_REG;
    bus.bsel     = ALUB_REG;
    bus.alusel   = ALU_ADD;
    bus.mdrwrite = 1'b0;
    bus.dmem_ren = 1'b0;
    bus.dmem_wen = 1'b0;
    bus.illegal  = 1'b0;

    case (state)
      FETCH: begin
        bus.irwrite = 1'b1;
        bus.pccen   = 1'b1;
        bus.pcwrite = 1'b1;
        state_nxt   = DECODE;
      end

      // Branch/JAL target is computed here and lands in aluout for EXEC
      DECODE: begin
        bus.asel   = ALUA_PCC;
        bus.bsel   = ALUB_IMM;
        bus.immsel = (cls == CLS_JAL) ? IMM_J : IMM_B;
        if (legal) begin
          state_nxt = EXEC;
        end else begin
`ifdef RV_CTL_ILLEGAL_EN
          state_nxt = HALT;
`else
          state_nxt = FETCH;
`endif
        end
      end

      EXEC: begin
        bus.alusel = alu_op;
        state_nxt  = FETCH;
        case (cls)
          CLS_R: state_nxt = WB;
          CLS_I, CLS_JALR: begin
            bus.bsel   = ALUB_IMM;
            bus.immsel = imm_op;
            state_nxt  = WB;
          end
          CLS_LW, CLS_SW: begin
            bus.bsel   = ALUB_IMM;
            bus.immsel = imm_op;
            state_nxt  = MEM;
          end
          CLS_BR: begin
            bus.pcwrite  = taken;
            bus.pcsourse = PC_ALU;
          end
          CLS_JAL: begin
            bus.alusel   = ALU_ADD;
            bus.regwen   = 1'b1;
            bus.wbsel    = WB_PC;
            bus.pcwrite  = 1'b1;
            bus.pcsourse = PC_ALU;
          end
          default: ;
        endcase
      end

      MEM: begin
        state_nxt = FETCH;
        if (cls == CLS_LW) begin
          bus.dmem_ren = 1'b1;
          bus.mdrwrite = 1'b1;
          state_nxt    = WB;
        end else if (cls == CLS_SW) begin
          bus.dmem_wen = 1'b1;
        end
      end

      // Link value is the PC before this edge, i.e. instruction address + 4
      WB: begin
        state_nxt = FETCH;
        case (cls)
          CLS_R, CLS_I: begin
            bus.regwen = 1'b1;
            bus.wbsel  = WB_ALUOUT;
          end
          CLS_LW: begin
            bus.regwen = 1'b1;
            bus.wbsel  = WB_MDR;
          end
          CLS_JALR: begin
            bus.regwen   = 1'b1;
            bus.wbsel    = WB_PC;
            bus.pcwrite  = 1'b1;
            bus.pcsourse = PC_ALU;
          end
          default: ;
        endcase
      end

`ifdef RV_CTL_ILLEGAL_EN
      HALT: begin
        bus.illegal = 1'b1;
        state_nxt   = HALT;
      end
`endif

      default: state_nxt = FETCH;
    endcase
  end

endmodule
